// File: rtl/snow64_sliced_simd_alu.sv
// Byte-serial SIMD ALU: one 8-bit slice of the operands is processed per
// cycle, with carries and lane-wide results kept inside 8/16/32/64-bit lanes.
module snow64_sliced_simd_alu #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [3:0]            in_oper,
  input  logic [1:0]            in_type_size,
  input  logic                  in_signedness,
  input  logic                  in_saturate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_illegal
);

  localparam int NUM_SLICES = DATA_WIDTH / 8;
  localparam int CW         = $clog2(NUM_SLICES);
  localparam int SW         = CW + 3;

  localparam logic [3:0] OP_ADD      = 4'd0;
  localparam logic [3:0] OP_SUB      = 4'd1;
  localparam logic [3:0] OP_SLT      = 4'd2;
  localparam logic [3:0] OP_AND      = 4'd5;
  localparam logic [3:0] OP_ORR      = 4'd6;
  localparam logic [3:0] OP_XOR      = 4'd7;
  localparam logic [3:0] OP_INV      = 4'd10;
  localparam logic [3:0] OP_NOT      = 4'd11;
  localparam logic [3:0] OP_ADDAGAIN = 4'd12;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [3:0]            oper_q;
  logic [1:0]            size_q;
  logic                  signed_q, sat_q;
  logic [CW-1:0]         slice_q;
  logic                  carry_q, nz_q, illegal_q;

  logic [CW-1:0]         lane_lmask;
  logic [SW-1:0]         span_sh, slice_base, lane_base, msb_pos;
  logic                  lane_low, lane_top, last_slice;
  logic [DATA_WIDTH-1:0] lane_mask, lane_one, lane_msb;
  logic [7:0]            a_s, b_s, b_eff, sum_s, slice_val;
  logic [8:0]            sum9;
  logic                  is_add, is_sub, cin, cout, ovf_s, nz;
  logic                  lane_write, illegal_op;
  logic [DATA_WIDTH-1:0] lane_val;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_data    = result_q;
  assign out_illegal = illegal_q;

  // Lane geometry: which slices form the current lane and where its bits sit
  always_comb begin
    lane_lmask = '0;
    span_sh    = SW'(DATA_WIDTH - 8);
    case (size_q)
      2'd0: begin lane_lmask = CW'(0); span_sh = SW'(DATA_WIDTH - 8);  end
      2'd1: begin lane_lmask = CW'(1); span_sh = SW'(DATA_WIDTH - 16); end
      2'd2: begin lane_lmask = CW'(3); span_sh = SW'(DATA_WIDTH - 32); end
      default: begin lane_lmask = CW'(7); span_sh = SW'(DATA_WIDTH - 64); end
    endcase
  end

  assign lane_low   = ((slice_q & lane_lmask) == '0);
  assign lane_top   = ((slice_q & lane_lmask) == lane_lmask);
  assign last_slice = (slice_q == CW'(NUM_SLICES - 1));
  assign slice_base = {slice_q, 3'b000};
  assign lane_base  = {slice_q & ~lane_lmask, 3'b000};
  assign msb_pos    = {slice_q, 3'b111};
  assign lane_mask  = ({DATA_WIDTH{1'b1}} >> span_sh) << lane_base;
  assign lane_one   = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << lane_base;
  assign lane_msb   = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << msb_pos;

  // Slice datapath: 8-bit adder with lane-local carry, sign overflow and zero tracking
  always_comb begin
    a_s    = a_q[slice_base +: 8];
    b_s    = b_q[slice_base +: 8];
    is_add = (oper_q == OP_ADD) || (oper_q == OP_ADDAGAIN);
    is_sub = (oper_q == OP_SUB) || (oper_q == OP_SLT);
    b_eff  = is_sub ? ~b_s : b_s;
    cin    = lane_low ? is_sub : carry_q;
    sum9   = {1'b0, a_s} + {1'b0, b_eff} + {8'd0, cin};
    cout   = sum9[8];
    sum_s  = sum9[7:0];
    ovf_s  = (a_s[7] == b_eff[7]) && (sum_s[7] != a_s[7]);
    nz     = (lane_low ? 1'b0 : nz_q) | (|a_s);
  end

  // Result update: write this slice, then patch the whole lane at its top slice
  always_comb begin
    result_d   = result_q;
    slice_val  = sum_s;
    lane_write = 1'b0;
    lane_val   = '0;
    illegal_op = 1'b0;
    case (oper_q)
      OP_ADD, OP_ADDAGAIN, OP_SUB: begin
        slice_val = sum_s;
        if (sat_q && lane_top) begin
          if (signed_q) begin
            lane_write = ovf_s;
            lane_val   = a_s[7] ? lane_msb : (lane_mask & ~lane_msb);
          end else if (is_add) begin
            lane_write = cout;
            lane_val   = lane_mask;
          end else begin
            lane_write = ~cout;
            lane_val   = '0;
          end
        end
      end
      OP_SLT: begin
        slice_val  = 8'd0;
        lane_write = lane_top;
        lane_val   = (signed_q ? (sum_s[7] ^ ovf_s) : ~cout) ? lane_one : '0;
      end
      OP_AND: slice_val = a_s & b_s;
      OP_ORR: slice_val = a_s | b_s;
      OP_XOR: slice_val = a_s ^ b_s;
      OP_INV: slice_val = ~a_s;
      OP_NOT: begin
        slice_val  = 8'd0;
        lane_write = lane_top;
        lane_val   = nz ? '0 : lane_one;
      end
      default: begin
        slice_val  = 8'd0;
        illegal_op = 1'b1;
      end
    endcase
    result_d[slice_base +: 8] = slice_val;
    if (lane_write) begin
      result_d = (result_d & ~lane_mask) | (lane_val & lane_mask);
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept in IDLE, walk the slices in BUSY, hold in DONE until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, slice counter, carry/zero chain and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      oper_q    <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      sat_q     <= 1'b0;
      slice_q   <= '0;
      carry_q   <= 1'b0;
      nz_q      <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q       <= in_a;
      b_q       <= in_b;
      oper_q    <= in_oper;
      size_q    <= in_type_size;
      signed_q  <= in_signedness;
      sat_q     <= in_saturate;
      slice_q   <= '0;
      carry_q   <= 1'b0;
      nz_q      <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (state_q == BUSY) begin
      result_q <= result_d;
      carry_q  <= cout;
      nz_q     <= nz;
      slice_q  <= slice_q + CW'(1);
      if (last_slice) illegal_q <= illegal_op;
    end
  end

endmodule

// File: doc/snow64_sliced_simd_alu.md
SNOW64_SLICED_SIMD_ALU -- requirements
Module: snow64_sliced_simd_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand/result width; legal values 64, 128, 256.
REQ-002 SHALL have derived constant NUM_SLICES = DATA_WIDTH/8, the number of 8-bit slices, processed one per cycle.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have ports in_a, in_b  input  DATA_WIDTH each  operands.
REQ-008 SHALL have port in_oper  input  4  op code: Add=0, Sub=1, Slt=2, And=5, Orr=6, Xor=7, Shl=8, Shr=9, Inv=10, Not=11, AddAgain=12; 3,4,13,14,15 are dummies.
REQ-009 SHALL have port in_type_size  input  2  lane width: 0=8, 1=16, 2=32, 3=64 bits.
REQ-010 SHALL have ports in_signedness, in_saturate  input  1 each  signed compare/saturation; saturating add/sub.
REQ-011 SHALL have port out_valid  output  1  result held and valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have ports out_data  output  DATA_WIDTH  result; out_illegal  output  1  op was not executable.

Function
REQ-014 SHALL use FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE & in_valid SHALL capture all in_* into registers, clear slice counter and result register, and go to BUSY.
REQ-016 BUSY SHALL process slice k (bits 8k+7:8k) in cycle k, k = 0..NUM_SLICES-1, then enter DONE after slice NUM_SLICES-1; out_valid rises exactly NUM_SLICES cycles after the accept edge.
REQ-017 DONE SHALL hold out_data and out_illegal stable until out_ready=1, then return to IDLE; no request is accepted in the same cycle as out_ready.
REQ-018 Carry/borrow SHALL chain slice-to-slice within a lane and SHALL be reset to 0 (Add/AddAgain) or 1 (Sub, a+~b+1) at each lane's lowest slice; no carry crosses a lane boundary.
REQ-019 And/Orr/Xor/Inv SHALL be bitwise per slice; Inv = ~a, b ignored.
REQ-020 Slt SHALL write 1 to bit 0 of the lane and 0 to all other lane bits; signed uses the a-b sign xor overflow, unsigned uses the borrow at the lane top slice.
REQ-021 Not SHALL write 1 to the lane if every a bit in the lane is 0, else 0 (logical not).
REQ-022 Lane-wide results (Slt, Not, saturation) SHALL be resolved at the lane's top slice and written into the already-stored lower slices in the same cycle.
REQ-023 in_saturate=1 with Add/Sub/AddAgain SHALL clamp on overflow: unsigned to all-ones (add) or zero (sub), signed to lane max/min; otherwise modular; in_saturate ignored for other ops.
REQ-024 Shl, Shr and dummy codes SHALL produce out_data=0 and out_illegal=1 after the same NUM_SLICES latency; all other ops give out_illegal=0.
REQ-025 Lane width exceeding DATA_WIDTH is impossible (minimum DATA_WIDTH 64); lanes SHALL tile DATA_WIDTH exactly.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, out_data=0, out_illegal=0, slice counter 0, carry 0.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation; the pending result is discarded and never presented.
REQ-028 After rst_n deasserts, the first request SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-029 DATA_WIDTH=64, Add, size 0, a=0x00000000000000FF, b=0x0000000000000001 -> out_data=0x0000000000000000 (no carry into byte 1), out_valid 8 cycles after accept.
REQ-030 Add, size 3, same operands -> 0x0000000000000100; with in_saturate=1, unsigned, a=all-ones, b=1 -> all-ones.
REQ-031 Slt signed, size 1, a=0x0000000000008000, b=0x0000000000000001 -> 0x0000000000000001; unsigned -> 0x0000000000000000.
REQ-032 Not, size 2, a=0x0000000100000000 -> 0x0000000000000001; Shl any operands -> out_data=0, out_illegal=1.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE next cycle.
REQ-034 DATA_WIDTH=128: assert rst_n=0 at slice 7 of 16 -> outputs zero immediately, no out_valid; new request afterward completes in 16 cycles with correct data.
